// File: rtl/sync_fifo_ctrl_mem_if.sv
// Producer/consumer bundle for sync_fifo_ctrl_mem. The master drives the requests and write data.
// The slave (the FIFO) returns read data, occupancy and status flags.
interface sync_fifo_ctrl_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Handshake: w_en/r_en are requests sampled on the rising clock edge.
  // A write is taken when w_en & !full, and a read is taken when r_en & !empty.
  // Both tests use the flags as they stand before that edge.
  // A request that is not taken raises overflow/underflow for exactly one cycle, on the next cycle.
  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, data_in, r_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, data_in, r_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl_mem.sv
// Single-clock FIFO with storage, wrap-around pointers, occupancy count, flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; otherwise data_out is registered.
module sync_fifo_ctrl_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input logic                clk,
  input logic                rst_n,
  sync_fifo_ctrl_mem_if.slave bus
);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_W     = PTR_WIDTH + 1;

  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]     DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     AF_C     = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]     AE_C     = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wptr, rptr;
  logic [PTR_WIDTH-1:0]  wptr_nxt, rptr_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  overflow_q, underflow_q;
  logic                  full_w, empty_w;
  logic                  wr_ok, rd_ok;

  // The flags decode the registered count, so they add no latency.
  assign full_w  = (cnt == DEPTH_C);
  assign empty_w = (cnt == '0);

  assign wr_ok = bus.w_en & ~full_w;
  assign rd_ok = bus.r_en & ~empty_w;

  always_comb begin
    wptr_nxt = wptr;
    rptr_nxt = rptr;
    cnt_nxt  = cnt;
    if (wr_ok) wptr_nxt = (wptr == LAST_PTR) ? '0 : wptr + PTR_WIDTH'(1);
    if (rd_ok) rptr_nxt = (rptr == LAST_PTR) ? '0 : rptr + PTR_WIDTH'(1);
    case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = cnt + CNT_W'(1);
      2'b01:   cnt_nxt = cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      cnt         <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr        <= wptr_nxt;
      rptr        <= rptr_nxt;
      cnt         <= cnt_nxt;
      overflow_q  <= bus.w_en & full_w;
      underflow_q <= bus.r_en & empty_w;
    end
  end

  // The storage array has no reset. Reset empties the FIFO through the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= bus.data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // The head word is visible while the FIFO is not empty. When empty, data_out is stale.
  assign bus.data_out = mem[rptr];
`else
  logic [DATA_WIDTH-1:0] data_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     data_out_q <= '0;
    else if (rd_ok) data_out_q <= mem[rptr];
  end

  assign bus.data_out = data_out_q;
`endif

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.count        = cnt;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_ctrl_mem.sv
// Directed bench for sync_fifo_ctrl_mem (DEPTH=8, DATA_WIDTH=8, AF=6, AE=2).
// A vector table covers fill, drain and errors. Hand sequences cover wrap, simultaneous access and reset.
module tb_sync_fifo_ctrl_mem;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sync_fifo_ctrl_mem_if #(.DATA_WIDTH(8), .DEPTH(8)) bus ();

  sync_fifo_ctrl_mem #(
    .DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vector record ----------------
  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] din;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
    logic       chk_d;
    logic [7:0] dout;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Flags are listed by hand from the occupancy each vector reaches.
  task automatic add_vec(input logic w, input logic r, input logic [7:0] din, input int c,
                         input logic f, input logic e, input logic af, input logic ae,
                         input logic o, input logic u, input logic chk_d, input logic [7:0] dout);
    vec_t v;
    v.w = w; v.r = r; v.din = din; v.cnt = 4'(c);
    v.full = f; v.empty = e; v.af = af; v.ae = ae;
    v.ovf = o; v.udf = u; v.chk_d = chk_d; v.dout = dout;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    bus.w_en    = w;
    bus.r_en    = r;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_data(input string name, input logic [7:0] reg_exp, input logic [7:0] head_exp);
`ifdef SYNC_FIFO_FWFT_EN
    check(name, bus.data_out, head_exp);
`else
    check(name, bus.data_out, reg_exp);
`endif
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] e;
    logic [7:0] last;
    checks = 0;
    errors = 0;

    // Table: idle, fill 0x11..0x88, overflow, drain, underflow. Data checks apply to registered read.
    //      w  r  din    cnt f  e  af ae o  u  chk dout
    add_vec(0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 1, 8'h00);
    add_vec(1, 0, 8'h11, 1, 0, 0, 0, 1, 0, 0, 1, 8'h00);
    add_vec(1, 0, 8'h22, 2, 0, 0, 0, 1, 0, 0, 1, 8'h00);
    add_vec(1, 0, 8'h33, 3, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    add_vec(1, 0, 8'h44, 4, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    add_vec(1, 0, 8'h55, 5, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    add_vec(1, 0, 8'h66, 6, 0, 0, 1, 0, 0, 0, 1, 8'h00);
    add_vec(1, 0, 8'h77, 7, 0, 0, 1, 0, 0, 0, 1, 8'h00);
    add_vec(1, 0, 8'h88, 8, 1, 0, 1, 0, 0, 0, 1, 8'h00);
    add_vec(1, 0, 8'h99, 8, 1, 0, 1, 0, 1, 0, 1, 8'h00);
    add_vec(0, 0, 8'h00, 8, 1, 0, 1, 0, 0, 0, 1, 8'h00);
    add_vec(0, 1, 8'h00, 7, 0, 0, 1, 0, 0, 0, 1, 8'h11);
    add_vec(0, 1, 8'h00, 6, 0, 0, 1, 0, 0, 0, 1, 8'h22);
    add_vec(0, 1, 8'h00, 5, 0, 0, 0, 0, 0, 0, 1, 8'h33);
    add_vec(0, 1, 8'h00, 4, 0, 0, 0, 0, 0, 0, 1, 8'h44);
    add_vec(0, 1, 8'h00, 3, 0, 0, 0, 0, 0, 0, 1, 8'h55);
    add_vec(0, 1, 8'h00, 2, 0, 0, 0, 1, 0, 0, 1, 8'h66);
    add_vec(0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 8'h77);
    add_vec(0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 0, 1, 8'h88);
    add_vec(0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 1, 1, 8'h88);
    add_vec(0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 1, 8'h88);

    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = 8'h00;
    rst_n       = 1'b0;
    #1;
    check("reset count", bus.count, 4'd0);
    check("reset empty", bus.empty, 1'b1);
    check("reset almost_empty", bus.almost_empty, 1'b1);
    check("reset full", bus.full, 1'b0);
    check("reset almost_full", bus.almost_full, 1'b0);
    check("reset overflow", bus.overflow, 1'b0);
    check("reset underflow", bus.underflow, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    check("reset data_out", bus.data_out, 8'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].w, vecs[i].r, vecs[i].din);
      check($sformatf("vec%0d count", i), bus.count, vecs[i].cnt);
      check($sformatf("vec%0d full", i), bus.full, vecs[i].full);
      check($sformatf("vec%0d empty", i), bus.empty, vecs[i].empty);
      check($sformatf("vec%0d almost_full", i), bus.almost_full, vecs[i].af);
      check($sformatf("vec%0d almost_empty", i), bus.almost_empty, vecs[i].ae);
      check($sformatf("vec%0d overflow", i), bus.overflow, vecs[i].ovf);
      check($sformatf("vec%0d underflow", i), bus.underflow, vecs[i].udf);
`ifndef SYNC_FIFO_FWFT_EN
      if (vecs[i].chk_d) check($sformatf("vec%0d data_out", i), bus.data_out, vecs[i].dout);
`endif
    end

    // Steady state at count 4 with both pointers wrapping.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'(8'hA0 + i));
      exp_q.push_back(8'(8'hA0 + i));
    end
    check("fill4 count", bus.count, 4'd4);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(8'hB0 + i));
      exp_q.push_back(8'(8'hB0 + i));
      e = exp_q.pop_front();
      check($sformatf("stream%0d count", i), bus.count, 4'd4);
      check($sformatf("stream%0d overflow", i), bus.overflow, 1'b0);
      check($sformatf("stream%0d underflow", i), bus.underflow, 1'b0);
      check_data($sformatf("stream%0d data_out", i), e, exp_q[0]);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00);
      e = exp_q.pop_front();
      check_data($sformatf("drain%0d data_out", i), e, (exp_q.size() > 0) ? exp_q[0] : bus.data_out);
    end
    check("drain count", bus.count, 4'd0);
    check("drain empty", bus.empty, 1'b1);

    // Simultaneous write and read while full: the read is taken and the write is rejected.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(8'hC0 + i));
      exp_q.push_back(8'(8'hC0 + i));
    end
    check("full count", bus.count, 4'd8);
    step(1'b1, 1'b1, 8'hEE);
    e = exp_q.pop_front();
    check("full_wr_rd count", bus.count, 4'd7);
    check("full_wr_rd overflow", bus.overflow, 1'b1);
    check("full_wr_rd underflow", bus.underflow, 1'b0);
    check_data("full_wr_rd data_out", e, exp_q[0]);
    last = e;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 8'h00);
      last = exp_q.pop_front();
      check_data($sformatf("unload%0d data_out", i), last, (exp_q.size() > 0) ? exp_q[0] : bus.data_out);
    end
    check("unload count", bus.count, 4'd0);
    check("unload overflow", bus.overflow, 1'b0);

    // Simultaneous write and read while empty: the write is taken with no bypass.
    step(1'b1, 1'b1, 8'h5A);
    check("empty_wr_rd count", bus.count, 4'd1);
    check("empty_wr_rd underflow", bus.underflow, 1'b1);
    check_data("empty_wr_rd data_out", last, 8'h5A);
    step(1'b0, 1'b0, 8'h00);
    check("empty_wr_rd pulse width", bus.underflow, 1'b0);
    step(1'b0, 1'b1, 8'h00);
    check("read 5A count", bus.count, 4'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("read 5A data_out", bus.data_out, 8'h5A);
`endif

    // Asynchronous reset in the middle of a write burst.
    step(1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    check("burst count", bus.count, 4'd2);
    @(negedge clk);
    bus.data_in = 8'h03;
    rst_n       = 1'b0;
    #1;
    check("async reset count", bus.count, 4'd0);
    check("async reset empty", bus.empty, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    check("async reset data_out", bus.data_out, 8'h00);
`endif
    @(negedge clk);
    rst_n    = 1'b1;
    bus.w_en = 1'b0;
    exp_q.delete();
    step(1'b0, 1'b1, 8'h00);
    check("post reset count", bus.count, 4'd0);
    check("post reset underflow", bus.underflow, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
